// File: rtl/cp0_unit_pkg.sv
// Shared CP0 definitions: register numbers, Status/Cause field positions,
// exception codes and the exception-mode FSM encoding.
package cp0_unit_pkg;

  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;

  localparam int ST_IE   = 0;
  localparam int ST_EXL  = 1;
  localparam int IM_LSB  = 8;
  localparam int IP_LSB  = 8;
  localparam int EXC_LSB = 2;
  localparam int EXC_MSB = 6;

  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_OV  = 5'd12;

  typedef enum logic {
    MODE_NORMAL  = 1'b0,
    MODE_HANDLER = 1'b1
  } mode_e;

endpackage

// File: rtl/cp0_unit_irq_sync_edge.sv
// Per-line 2-FF synchroniser followed by rising-edge detect; a rise on
// async_i appears on rise_o as a one-cycle pulse two clocks later, no backpressure.
module irq_sync_edge #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] rise_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/cp0_unit.sv
// Coprocessor 0: Status/Cause/EPC, interrupt latching and exception entry/return.
// exc_take is registered (one cycle after the causing event); MFC0 reads are combinational.
module cp0_unit
  import cp0_unit_pkg::*;
#(
  parameter int          NUM_IRQ    = 6,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0180
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cp0_wt,
  input  logic [4:0]         cp0_addr,
  input  logic [31:0]        cp0_wdata,
  output logic [31:0]        cp0_rdata,
  input  logic               eret,
  input  logic               ov_exc,
  input  logic               inst_boundary,
  input  logic [31:0]        pc_in,
  input  logic [NUM_IRQ-1:0] int_req,
  output logic               exc_take,
  output logic [31:0]        exc_vector,
  output logic [31:0]        epc_out,
  output logic               int_pending
);

  mode_e       mode_q, mode_d;
  logic        ie_q, ie_d;
  logic [7:0]  im_q, im_d;
  logic [7:0]  ip_q, ip_d;
  logic [4:0]  exc_code_q, exc_code_d;
  logic [31:0] epc_q, epc_d;
  logic        exc_take_q, exc_take_d;

  logic [NUM_IRQ-1:0] irq_rise;
  logic [7:0]         irq_set;
  logic               exl;
  logic               wr_status, wr_cause, wr_epc;
  logic               take_ov, take_int;

  irq_sync_edge #(.WIDTH(NUM_IRQ)) u_irq_sync (
    .clk     (clk),
    .reset   (reset),
    .async_i (int_req),
    .rise_o  (irq_rise)
  );

  // EXL is the FSM state itself, so the two can never disagree.
  assign exl       = (mode_q == MODE_HANDLER);
  assign wr_status = cp0_wt && (cp0_addr == CP0_STATUS);
  assign wr_cause  = cp0_wt && (cp0_addr == CP0_CAUSE);
  assign wr_epc    = cp0_wt && (cp0_addr == CP0_EPC);

  assign int_pending = (|(ip_q & im_q)) && ie_q && !exl;

  assign take_ov  = ov_exc && !exc_take_q;
  assign take_int = inst_boundary && int_pending && !eret && !ov_exc && !exc_take_q;

  always_comb begin
    irq_set                = '0;
    irq_set[NUM_IRQ-1:0]   = irq_rise;
  end

  always_comb begin
    mode_d     = mode_q;
    ie_d       = ie_q;
    im_d       = im_q;
    ip_d       = ip_q;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;
    exc_take_d = take_ov || take_int;

    if (wr_status) begin
      ie_d   = cp0_wdata[ST_IE];
      im_d   = cp0_wdata[IM_LSB +: 8];
      mode_d = cp0_wdata[ST_EXL] ? MODE_HANDLER : MODE_NORMAL;
    end
    if (wr_cause) begin
      ip_d       = cp0_wdata[IP_LSB +: 8];
      exc_code_d = cp0_wdata[EXC_MSB:EXC_LSB];
    end
    if (wr_epc) begin
      epc_d = cp0_wdata;
    end

    // Hardware-latched edges override a software clear in the same cycle.
    ip_d = ip_d | irq_set;

    if (eret) begin
      mode_d = MODE_NORMAL;
    end

    if (take_ov) begin
      exc_code_d = EXC_OV;
      mode_d     = MODE_HANDLER;
      if (!exl) begin
        epc_d = pc_in;
      end
    end else if (take_int) begin
      exc_code_d = EXC_INT;
      mode_d     = MODE_HANDLER;
      epc_d      = pc_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q     <= MODE_NORMAL;
      ie_q       <= 1'b0;
      im_q       <= '0;
      ip_q       <= '0;
      exc_code_q <= '0;
      epc_q      <= '0;
      exc_take_q <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      ie_q       <= ie_d;
      im_q       <= im_d;
      ip_q       <= ip_d;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
      exc_take_q <= exc_take_d;
    end
  end

  always_comb begin
    cp0_rdata = 32'h0;
    case (cp0_addr)
      CP0_STATUS: cp0_rdata = {16'h0, im_q, 6'h0, exl, ie_q};
      CP0_CAUSE:  cp0_rdata = {16'h0, ip_q, 1'b0, exc_code_q, 2'b00};
      CP0_EPC:    cp0_rdata = epc_q;
      default:    cp0_rdata = 32'h0;
    endcase
  end

  assign exc_take   = exc_take_q;
  assign exc_vector = EXC_VECTOR;
  assign epc_out    = epc_q;

endmodule

// File: doc/cp0_unit.md
Name: cp0_unit

Overview:
- Coprocessor-0 block for the multi-cycle MIPS CPU; sits directly downstream of the main controller (ctrl).
- Consumes the controller's cp0_wt strobe, ERET decode and overflow indication; holds Status, Cause and EPC.
- Synchronises and latches external interrupts and decides exception entry at instruction boundaries.
- Returns exception-entry and return-address information to the controller and PC path.

Parameters:
- NUM_IRQ, 6, number of external interrupt lines (1..8), mapped to Cause.IP[NUM_IRQ-1:0] (bits 8+i)
- EXC_VECTOR, 32'h0000_0180, PC loaded on exception entry

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cp0_wt  in  1  MTC0 write strobe from ctrl, one cycle
- cp0_addr  in  5  CP0 register number (instruction rd field)
- cp0_wdata  in  32  MTC0 write data (rt value)
- cp0_rdata  out  32  MFC0 read data, combinational from cp0_addr
- eret  in  1  ERET execute strobe from ctrl, one cycle
- ov_exc  in  1  arithmetic-overflow exception strobe from ctrl, one cycle
- inst_boundary  in  1  ctrl is in the fetch state; interrupts are accepted only here
- pc_in  in  32  PC of the instruction to resume/refault at
- int_req  in  NUM_IRQ  asynchronous external interrupt requests, level
- exc_take  out  1  one-cycle pulse: redirect PC to exc_vector
- exc_vector  out  32  constant EXC_VECTOR
- epc_out  out  32  current EPC, used by ctrl as the ERET target
- int_pending  out  1  |(IP & IM) && IE && !EXL

Behaviour:
- Registers:
  - Status (12): bit0 IE, bit1 EXL, [15:8] IM; all other bits read 0.
  - Cause (13): [15:8] IP, [6:2] ExcCode; all other bits read 0.
  - EPC (14): 32 bits.
  - Any other cp0_addr reads 32'h0; writes to it are ignored.
- Reset (async): Status=0, Cause=0, EPC=0, synchronisers=0, exc_take=0, mode=NORMAL.
- Interrupt input path:
  - 2-FF synchroniser per line, then rising-edge detect.
  - A rising edge sets the IP bit (sticky).
  - MTC0 to Cause writes IP and ExcCode.
  - Hardware IP set beats a simultaneous software clear of the same bit.
- FSM, 2 states:
  - NORMAL to HANDLER on exception entry; sets EXL=1.
  - HANDLER to NORMAL on eret; clears EXL=0.
  - An MTC0 that writes EXL also moves the FSM to match.
- Exception entry, evaluated every cycle; priority ov_exc > interrupt:
  - ov_exc=1: ExcCode<=12; EPC<=pc_in only if EXL==0; EXL<=1; exc_take=1 next cycle. IE is ignored. Taken even in HANDLER (EPC preserved).
  - Interrupt: requires inst_boundary && int_pending. Then ExcCode<=0, EPC<=pc_in, EXL<=1, exc_take=1 next cycle.
- exc_take:
  - Registered; exactly one cycle per accepted exception.
  - No new entry is accepted while exc_take=1.
- eret:
  - EXL<=0; epc_out is stable throughout that cycle.
  - eret and an interrupt in the same cycle: eret wins. The interrupt is re-evaluated at the next boundary.
  - eret and ov_exc in the same cycle: ov_exc wins.
- MTC0 in the same cycle as exception entry:
  - Entry wins for EPC, Status.EXL and Cause.ExcCode.
  - All other written fields update normally.
- cp0_rdata reflects register contents; a write is visible on the cycle after cp0_wt.

Decomposition:
- Shared package/header:
  - CP0 register numbers: STATUS=12, CAUSE=13, EPC=14.
  - Bit positions: IE, EXL, IM/IP base, ExcCode field.
  - ExcCode constants: INT=0, OV=12.
  - FSM state encodings.
- One natural sub-module: irq_sync_edge (2-FF synchroniser plus rising-edge detect, per line, width NUM_IRQ).

Test Plan:
- Reset mid-operation: reset=1 while EXL=1 and EPC=32'h40 -> all CP0 registers read 0 immediately, exc_take=0.
- Interrupt entry:
  - Stimulus: MTC0 Status=32'h0000_0101, then int_req[0] rises, inst_boundary=1, pc_in=32'h0000_0024.
  - Response: within 4 cycles exc_take pulses for exactly 1 cycle; EPC=32'h24; Cause=32'h0000_0100; Status=32'h0000_0103.
- Interrupts masked:
  - Stimulus: same as interrupt entry, but Status=32'h0000_0001 (IM=0).
  - Response: IP[0]=1 is latched; exc_take stays 0; int_pending=0.
- Overflow while in handler:
  - Stimulus: EXL=1, EPC=32'h24; pulse ov_exc with pc_in=32'h0000_0188.
  - Response: exc_take pulses; Cause.ExcCode=12 (Cause[6:2]=5'h0C); EPC stays 32'h24.
- ERET with simultaneous interrupt:
  - Stimulus: eret=1 in the same cycle as a pending interrupt at inst_boundary.
  - Response: EXL=0 and no exc_take that cycle; entry happens at the next boundary with EPC=new pc_in.
- MTC0/entry collision:
  - Stimulus: cp0_wt to EPC with 32'hDEAD_BEE0 in the same cycle as ov_exc, EXL=0, pc_in=32'h0000_0030.
  - Response: EPC=32'h30; cp0_rdata on EPC shows 32'h30 the next cycle.
